// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: issues sequential 16-bit fetches (one outstanding at a time)
// into a small FIFO, with redirect flushing and discard of an in-flight response.
module instr_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'd99
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   redirect,
    input  logic [15:0]            redirect_pc,
    output logic                   mem_req,
    output logic [15:0]            mem_addr,
    input  logic                   mem_ack,
    input  logic [15:0]            mem_rdata,
    output logic                   ir_valid,
    input  logic                   ir_ready,
    output logic [15:0]            ir_data,
    output logic [15:0]            ir_pc,
    output logic [$clog2(DEPTH):0] q_count
);

    localparam int unsigned   AW        = $clog2(DEPTH);
    localparam int unsigned   CW        = AW + 1;
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StFetch, StFlush} state_e;

    state_e        state_q, state_d;
    logic [15:0]   fetch_pc_q, fetch_pc_d;
    logic [15:0]   mem_addr_q, mem_addr_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [15:0]   data_mem_q [DEPTH];
    logic [15:0]   pc_mem_q   [DEPTH];
    logic          push, pop;
    logic [CW-1:0] post_count;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_addr_d = mem_addr_q;
        push       = 1'b0;
        pop        = (count_q != '0) && ir_ready;
        post_count = count_q + CW'(1) - CW'(pop);

        if (redirect) begin
            fetch_pc_d = redirect_pc;
            // An unacked request must still be drained; its data is dropped in StFlush.
            unique case (state_q)
                StIdle:  state_d = StIdle;
                default: state_d = mem_ack ? StIdle : StFlush;
            endcase
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (count_q < FullCount) begin
                        state_d    = StFetch;
                        mem_addr_d = fetch_pc_q;
                    end
                end
                StFetch: begin
                    if (mem_ack) begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + 16'd1;
                        if (post_count < FullCount) begin
                            mem_addr_d = fetch_pc_d;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                StFlush: begin
                    if (mem_ack) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (redirect) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            count_d  = count_q + CW'(push) - CW'(pop);
            rd_ptr_d = rd_ptr_q + AW'(pop);
            wr_ptr_d = wr_ptr_q + AW'(push);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            mem_addr_q <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_addr_q <= mem_addr_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= mem_rdata;
            pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
        end
    end

    assign mem_req  = (state_q != StIdle);
    assign mem_addr = mem_addr_q;
    assign ir_valid = (count_q != '0);
    assign ir_data  = ir_valid ? data_mem_q[rd_ptr_q] : '0;
    assign ir_pc    = ir_valid ? pc_mem_q[rd_ptr_q] : '0;
    assign q_count  = count_q;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Self-checking bench for instr_prefetch_queue: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_instr_prefetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [15:0] RESET_PC = 16'd99;

    logic        clk;
    logic        reset;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        ir_valid;
    logic        ir_ready;
    logic [15:0] ir_data;
    logic [15:0] ir_pc;
    logic [2:0]  q_count;

    int passed = 0;
    int total  = 0;

    instr_prefetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .ir_data     (ir_data),
        .ir_pc       (ir_pc),
        .q_count     (q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] memf(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    assign mem_rdata = memf(mem_addr);

    always @(posedge clk) begin
        if (!reset && dut.push) begin
            assert (int'(dut.count_q) < DEPTH)
            else $error("FAIL push_while_full: count %0d, want < %0d", dut.count_q, DEPTH);
        end
    end

    // Reference model: list of fetched pcs plus the one outstanding request.
    logic [15:0] mq_pc[$];
    logic [15:0] m_fetch = RESET_PC;
    logic [15:0] m_addr  = '0;
    bit          m_out   = 1'b0;
    bit          m_disc  = 1'b0;
    bit          m_rst   = 1'b0;

    task automatic model_edge();
        bit acked;
        bit do_pop;
        int was_size;
        if (reset) begin
            mq_pc.delete();
            m_fetch = RESET_PC;
            m_out   = 1'b0;
            m_disc  = 1'b0;
            m_addr  = '0;
            m_rst   = 1'b1;
            return;
        end
        m_rst    = 1'b0;
        acked    = m_out && mem_ack;
        was_size = mq_pc.size();
        if (redirect) begin
            mq_pc.delete();
            m_fetch = redirect_pc;
            if (m_out && !acked) begin
                m_disc = 1'b1;
            end else begin
                m_out  = 1'b0;
                m_disc = 1'b0;
            end
        end else begin
            do_pop = ir_ready && (was_size > 0);
            if (do_pop) void'(mq_pc.pop_front());
            if (!m_out) begin
                if (was_size < DEPTH) begin
                    m_out  = 1'b1;
                    m_addr = m_fetch;
                end
            end else if (acked) begin
                if (m_disc) begin
                    m_out  = 1'b0;
                    m_disc = 1'b0;
                end else begin
                    mq_pc.push_back(m_fetch);
                    m_fetch = m_fetch + 16'd1;
                    if (mq_pc.size() < DEPTH) m_addr = m_fetch;
                    else m_out = 1'b0;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        else passed++;
    endtask

    task automatic compare_model();
        logic [15:0] hp;
        hp = (mq_pc.size() > 0) ? mq_pc[0] : 16'h0;
        check("mem_req", 16'(mem_req), 16'(m_out));
        if (m_out || m_rst) check("mem_addr", mem_addr, m_addr);
        check("ir_valid", 16'(ir_valid), 16'(mq_pc.size() > 0));
        check("ir_pc", ir_pc, hp);
        check("ir_data", ir_data, (mq_pc.size() > 0) ? memf(hp) : 16'h0);
        check("q_count", 16'(q_count), 16'(mq_pc.size()));
    endtask

    task automatic drive(input logic rst, input logic rdr, input logic [15:0] rpc,
                         input logic ack, input logic rdy);
        reset       = rst;
        redirect    = rdr;
        redirect_pc = rpc;
        mem_ack     = ack;
        ir_ready    = rdy;
    endtask

    task automatic tick(input bit cmp_model);
        @(posedge clk);
        model_edge();
        #1;
        if (cmp_model) compare_model();
    endtask

    typedef struct {
        logic        rst;
        logic        rdr;
        logic [15:0] rpc;
        logic        ack;
        logic        rdy;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_val;
        logic [15:0] e_pc;
        int          e_cnt;
    } vec_t;

    vec_t tbl[10];

    initial begin
        drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);

        // Sequential fetch from reset, then wrap through 16'hFFFF.
        tbl[0] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd0,    1'b0, 16'h0000, 0};
        tbl[1] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'd99,   1'b0, 16'h0000, 0};
        tbl[2] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'd100,  1'b1, 16'd99,   1};
        tbl[3] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'd101,  1'b1, 16'd100,  1};
        tbl[4] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'd102,  1'b1, 16'd101,  1};
        tbl[5] = '{1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 0};
        tbl[6] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hFFFE, 1'b0, 16'h0000, 0};
        tbl[7] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b1, 16'hFFFE, 1};
        tbl[8] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 16'hFFFF, 1};
        tbl[9] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0001, 1'b1, 16'h0000, 1};

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].rst, tbl[i].rdr, tbl[i].rpc, tbl[i].ack, tbl[i].rdy);
            tick(1'b0);
            check($sformatf("v%0d_mem_req", i), 16'(mem_req), 16'(tbl[i].e_req));
            if (tbl[i].e_req || tbl[i].rst)
                check($sformatf("v%0d_mem_addr", i), mem_addr, tbl[i].e_addr);
            check($sformatf("v%0d_ir_valid", i), 16'(ir_valid), 16'(tbl[i].e_val));
            check($sformatf("v%0d_ir_pc", i), ir_pc, tbl[i].e_pc);
            check($sformatf("v%0d_ir_data", i), ir_data,
                  tbl[i].e_val ? memf(tbl[i].e_pc) : 16'h0);
            check($sformatf("v%0d_q_count", i), 16'(q_count), 16'(tbl[i].e_cnt));
        end

        // Fill to DEPTH with no consumer, then release exactly one entry.
        drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0); tick(1'b1);
        drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) tick(1'b1);
        check("full_count", 16'(q_count), 16'd4);
        check("full_no_req", 16'(mem_req), 16'd0);
        drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b1); tick(1'b1);
        drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0); tick(1'b1);
        check("refill_req", 16'(mem_req), 16'd1);
        check("refill_addr", mem_addr, 16'd103);
        tick(1'b1);
        check("refill_done", 16'(mem_req), 16'd0);

        // Redirect with the response to 103 held off for three cycles.
        drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0); tick(1'b1);
        drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) tick(1'b1);
        check("pre_redirect_addr", mem_addr, 16'd103);
        drive(1'b0, 1'b1, 16'd200, 1'b0, 1'b1); tick(1'b1);
        check("flush_addr_held", mem_addr, 16'd103);
        check("flush_req_held", 16'(mem_req), 16'd1);
        check("flush_count", 16'(q_count), 16'd0);
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1); tick(1'b1); tick(1'b1);
        check("flush_addr_held2", mem_addr, 16'd103);
        drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b1); tick(1'b1);
        check("flush_dropped", 16'(q_count), 16'd0);
        tick(1'b1);
        check("flush_next_addr", mem_addr, 16'd200);

        // Redirect coinciding with ack and pop while two entries are held.
        drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0); tick(1'b1);
        drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1);
        check("two_entries", 16'(q_count), 16'd2);
        drive(1'b0, 1'b1, 16'd300, 1'b1, 1'b1); tick(1'b1);
        check("same_edge_count", 16'(q_count), 16'd0);
        drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0); tick(1'b1);
        check("same_edge_next_addr", mem_addr, 16'd300);

        // Reset while flushing; late ack must not push.
        drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0); tick(1'b1);
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0); tick(1'b1);
        drive(1'b0, 1'b1, 16'd500, 1'b0, 1'b0); tick(1'b1);
        drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0); tick(1'b1);
        drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0); tick(1'b1);
        check("rst_flush_count", 16'(q_count), 16'd0);
        check("rst_flush_addr", mem_addr, 16'd99);
        tick(1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 63) == 0,
                  $urandom_range(0, 15) == 0,
                  ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                              : 16'($urandom),
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1);
            tick(1'b1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/instr_prefetch_queue.md
INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

Interface
REQ-001 Parameter: DEPTH, 4, queue entries; legal values 2, 4 or 8.
REQ-002 Parameter: RESET_PC, 16'd99, first fetch address after reset.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: redirect  input  1  flush the queue and restart fetch (branch/return taken).
REQ-006 Port: redirect_pc  input  16  new fetch address; sampled when redirect=1.
REQ-007 Port: mem_req  output  1  instruction-memory read request, registered.
REQ-008 Port: mem_addr  output  16  read address, registered; stable while mem_req=1.
REQ-009 Port: mem_ack  input  1  read data valid; meaningful only while mem_req=1.
REQ-010 Port: mem_rdata  input  16  instruction word, captured when mem_req & mem_ack.
REQ-011 Port: ir_valid  output  1  queue head holds a valid instruction.
REQ-012 Port: ir_ready  input  1  consumer (IR/decode) accepts the head.
REQ-013 Port: ir_data  output  16  head instruction word; 0 when empty.
REQ-014 Port: ir_pc  output  16  address of the head instruction; 0 when empty.
REQ-015 Port: q_count  output  clog2(DEPTH)+1  number of valid entries.

Function
REQ-016 FSM states: IDLE (no request), FETCH (request outstanding, data kept), FLUSH (request outstanding, data discarded).
REQ-017 At most one request is outstanding; mem_req = (state != IDLE).
REQ-018 IDLE->FETCH when count < DEPTH and redirect=0; mem_addr <= fetch_pc on that edge.
REQ-019 FETCH with ack and no redirect: push {fetch_pc, mem_rdata}; fetch_pc += 1; stay in FETCH with mem_addr = new fetch_pc if post-push count < DEPTH, else go to IDLE.
REQ-020 With mem_ack tied high, throughput is one instruction per cycle.
REQ-021 Push-to-visible latency: the entry is visible on ir_valid/ir_data/ir_pc in the cycle after the acking edge.
REQ-022 fetch_pc arithmetic is 16-bit modulo; 16'hFFFF increments to 16'h0000.
REQ-023 Pop occurs on an edge with ir_valid & ir_ready; the queue is FIFO-ordered.
REQ-024 Simultaneous push and pop leaves count unchanged; data order is preserved.
REQ-025 Push is never attempted when full, per the issue rule in REQ-018/019; a push while full is a design error and is flagged by a bench assertion.
REQ-026 Redirect, on any edge:
  - queue emptied (count=0, pending pop ignored);
  - fetch_pc <= redirect_pc.
REQ-027 Redirect in IDLE: next state IDLE; a request to redirect_pc may issue on the following edge.
REQ-028 Redirect in FETCH:
  - without ack: next state FLUSH; mem_req stays high at the old address until ack.
  - with ack on the same edge: the returning data is discarded; next state IDLE.
REQ-029 FLUSH with ack: data discarded; next state IDLE; fetch resumes at fetch_pc.
REQ-030 Redirect while in FLUSH: fetch_pc updated to the latest redirect_pc; state remains FLUSH until ack.
REQ-031 Combinational paths: none from mem_* inputs to ir_* outputs. ir_* outputs are driven from queue storage only.

Reset
REQ-032 Reset (sampled on the edge) overrides redirect, ack and pop:
  - state=IDLE, count=0, fetch_pc=RESET_PC;
  - mem_req=0, mem_addr=0, ir_valid=0, ir_data=0, ir_pc=0, q_count=0.
REQ-033 Reset during FETCH/FLUSH abandons the outstanding request. The memory ack for it, if it arrives after reset, is ignored because mem_req=0.

Verification
REQ-034 Reset release, mem_ack=1, ir_ready=1 -> mem_addr 99,100,101 on consecutive cycles; ir_pc 99,100,101 one cycle later; ir_data matches memory.
REQ-035 ir_ready=0, mem_ack=1, DEPTH=4 -> q_count reaches 4; mem_req drops to 0; raising ir_ready for one cycle -> exactly one pop, then one new request at the next sequential address.
REQ-036 Redirect to 16'd200 while FETCH at address 103, ack withheld 3 cycles -> mem_addr held at 103 until ack; word 103 not enqueued; next request at 200; q_count=0 the cycle after redirect.
REQ-037 Redirect on the same edge as ack and pop with 2 entries -> q_count=0, acked word dropped, next mem_addr=redirect_pc.
REQ-038 redirect_pc=16'hFFFE, mem_ack=1 -> ir_pc sequence FFFE, FFFF, 0000.
REQ-039 Reset asserted in FLUSH, ack arrives the following cycle -> no push; q_count=0; first post-reset request at address 99.
